// File: rtl/bomb_engine.sv
`default_nettype none
// ============================================================================
// bomb_engine : per-player bomb slots, fuse/blast timers, cross-shaped damage
// Revision    : 1.0
// ============================================================================
module bomb_engine #(
    parameter int GRID         = 10,
    parameter int SLOTS_PER    = 2,
    parameter int FUSE_TICKS   = 3,
    parameter int BLAST_TICKS  = 1,
    parameter int BLAST_RADIUS = 2
) (
    input  logic       clk,
    input  logic       reset_sw,
    input  logic       tick,
    input  logic       place_a,
    input  logic       place_b,
    input  logic [3:0] pa_x,
    input  logic [3:0] pa_y,
    input  logic [3:0] pb_x,
    input  logic [3:0] pb_y,
    input  logic [3:0] qry_x,
    input  logic [3:0] qry_y,
    output logic       qry_bomb,
    output logic       qry_blast,
    output logic [1:0] health_a,
    output logic [1:0] health_b,
    output logic       hit_a,
    output logic       hit_b,
    output logic [1:0] game_state
);
    localparam int SLOTS   = 2 * SLOTS_PER;
    localparam int IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_MAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_FUSE  = CNT_W'(FUSE_TICKS);
    localparam logic [CNT_W-1:0] CNT_BLAST = CNT_W'(BLAST_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0] GS_PLAY = 2'd0;
    localparam logic [1:0] GS_AWIN = 2'd1;
    localparam logic [1:0] GS_BWIN = 2'd2;
    localparam logic [1:0] GS_DRAW = 2'd3;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_FUSE  = 2'd1,
        SLOT_BLAST = 2'd2
    } slot_e;

    slot_e            state_q [SLOTS];
    slot_e            state_d [SLOTS];
    logic [CNT_W-1:0] cnt_q   [SLOTS];
    logic [CNT_W-1:0] cnt_d   [SLOTS];
    logic [3:0]       bx_q    [SLOTS];
    logic [3:0]       bx_d    [SLOTS];
    logic [3:0]       by_q    [SLOTS];
    logic [3:0]       by_d    [SLOTS];
    logic [1:0]       health_a_q, health_a_d, health_b_q, health_b_d;
    logic             hit_a_q, hit_a_d, hit_b_q, hit_b_d;
    logic [1:0]       gs_q, gs_d;

    logic             running, free_a, free_b, occ_a, occ_b, acc_a, acc_b;
    logic             dmg_a, dmg_b;
    logic [IDX_W-1:0] idx_a, idx_b;

    function automatic logic in_grid(input logic [3:0] x, input logic [3:0] y);
        return ({1'b0, x} < 5'(GRID)) && ({1'b0, y} < 5'(GRID));
    endfunction

    // Differences are taken in 5 bits so arms never wrap around the arena.
    function automatic logic in_cross(input logic [3:0] bx, input logic [3:0] by,
                                      input logic [3:0] x,  input logic [3:0] y);
        logic [4:0] dx, dy;
        dx = (x >= bx) ? ({1'b0, x} - {1'b0, bx}) : ({1'b0, bx} - {1'b0, x});
        dy = (y >= by) ? ({1'b0, y} - {1'b0, by}) : ({1'b0, by} - {1'b0, y});
        return in_grid(x, y) &&
               (((x == bx) && (dy <= 5'(BLAST_RADIUS))) ||
                ((y == by) && (dx <= 5'(BLAST_RADIUS))));
    endfunction

    always_comb begin
        qry_bomb  = 1'b0;
        qry_blast = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (state_q[i] == SLOT_FUSE && bx_q[i] == qry_x && by_q[i] == qry_y)
                qry_bomb = 1'b1;
            if (state_q[i] == SLOT_BLAST && in_cross(bx_q[i], by_q[i], qry_x, qry_y))
                qry_blast = 1'b1;
        end
    end

    // Placement arbitration; descending scan so the lowest idle slot wins.
    always_comb begin
        running = (gs_q == GS_PLAY);
        free_a  = 1'b0;
        free_b  = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        occ_a   = 1'b0;
        occ_b   = 1'b0;
        for (int i = SLOTS_PER - 1; i >= 0; i--) begin
            if (state_q[i] == SLOT_IDLE) begin
                free_a = 1'b1;
                idx_a  = IDX_W'(i);
            end
        end
        for (int i = SLOTS - 1; i >= SLOTS_PER; i--) begin
            if (state_q[i] == SLOT_IDLE) begin
                free_b = 1'b1;
                idx_b  = IDX_W'(i);
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            if (state_q[i] == SLOT_FUSE && bx_q[i] == pa_x && by_q[i] == pa_y)
                occ_a = 1'b1;
            if (state_q[i] == SLOT_FUSE && bx_q[i] == pb_x && by_q[i] == pb_y)
                occ_b = 1'b1;
        end
        acc_a = running && place_a && free_a && in_grid(pa_x, pa_y) && !occ_a;
        acc_b = running && place_b && free_b && in_grid(pb_x, pb_y) && !occ_b &&
                !(acc_a && pa_x == pb_x && pa_y == pb_y);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dmg_a   = 1'b0;
        dmg_b   = 1'b0;
        if (running && tick) begin
            for (int i = 0; i < SLOTS; i++) begin
                case (state_q[i])
                    SLOT_FUSE: begin
                        if (cnt_q[i] == CNT_ONE) begin
                            state_d[i] = SLOT_BLAST;
                            cnt_d[i]   = CNT_BLAST;
                            dmg_a      = dmg_a | in_cross(bx_q[i], by_q[i], pa_x, pa_y);
                            dmg_b      = dmg_b | in_cross(bx_q[i], by_q[i], pb_x, pb_y);
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    SLOT_BLAST: begin
                        if (cnt_q[i] == CNT_ONE) begin
                            state_d[i] = SLOT_IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (acc_a) begin
            state_d[idx_a] = SLOT_FUSE;
            cnt_d[idx_a]   = CNT_FUSE;
            bx_d[idx_a]    = pa_x;
            by_d[idx_a]    = pa_y;
        end
        if (acc_b) begin
            state_d[idx_b] = SLOT_FUSE;
            cnt_d[idx_b]   = CNT_FUSE;
            bx_d[idx_b]    = pb_x;
            by_d[idx_b]    = pb_y;
        end

        hit_a_d    = dmg_a && (health_a_q != 2'd0);
        hit_b_d    = dmg_b && (health_b_q != 2'd0);
        health_a_d = health_a_q - {1'b0, hit_a_d};
        health_b_d = health_b_q - {1'b0, hit_b_d};
        gs_d       = gs_q;
        if (running) begin
            if (health_a_d == 2'd0 && health_b_d == 2'd0) gs_d = GS_DRAW;
            else if (health_b_d == 2'd0)                  gs_d = GS_AWIN;
            else if (health_a_d == 2'd0)                  gs_d = GS_BWIN;
            else                                          gs_d = GS_PLAY;
        end
    end

    always_ff @(posedge clk or posedge reset_sw) begin
        if (reset_sw) begin
            for (int i = 0; i < SLOTS; i++) begin
                state_q[i] <= SLOT_IDLE;
                cnt_q[i]   <= '0;
                bx_q[i]    <= '0;
                by_q[i]    <= '0;
            end
            health_a_q <= 2'd3;
            health_b_q <= 2'd3;
            hit_a_q    <= 1'b0;
            hit_b_q    <= 1'b0;
            gs_q       <= GS_PLAY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            health_a_q <= health_a_d;
            health_b_q <= health_b_d;
            hit_a_q    <= hit_a_d;
            hit_b_q    <= hit_b_d;
            gs_q       <= gs_d;
        end
    end

    assign health_a   = health_a_q;
    assign health_b   = health_b_q;
    assign hit_a      = hit_a_q;
    assign hit_b      = hit_b_q;
    assign game_state = gs_q;
endmodule
`default_nettype wire

// File: tb/tb_bomb_engine.sv
`default_nettype none
// ============================================================================
// tb_bomb_engine : scoreboard bench for bomb_engine
// Revision       : 1.0
// ============================================================================
module tb_bomb_engine;
    logic       clk = 1'b0;
    logic       reset_sw, tick, place_a, place_b;
    logic [3:0] pa_x, pa_y, pb_x, pb_y, qry_x, qry_y;
    logic       qry_bomb, qry_blast, hit_a, hit_b;
    logic [1:0] health_a, health_b, game_state;

    int         n_tests = 0;
    int         n_fail  = 0;
    // Observation word: {hit_a, hit_b, health_a, health_b, game_state}
    logic [7:0] sb_q [$];
    logic [7:0] mon_q[$];

    bomb_engine dut (
        .clk        (clk),
        .reset_sw   (reset_sw),
        .tick       (tick),
        .place_a    (place_a),
        .place_b    (place_b),
        .pa_x       (pa_x),
        .pa_y       (pa_y),
        .pb_x       (pb_x),
        .pb_y       (pb_y),
        .qry_x      (qry_x),
        .qry_y      (qry_y),
        .qry_bomb   (qry_bomb),
        .qry_blast  (qry_blast),
        .health_a   (health_a),
        .health_b   (health_b),
        .hit_a      (hit_a),
        .hit_b      (hit_b),
        .game_state (game_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ex(input logic ha, input logic hb, input logic [1:0] lha,
                                      input logic [1:0] lhb, input logic [1:0] gs);
        return {ha, hb, lha, lhb, gs};
    endfunction

    task automatic step(input logic pa, input logic pb, input logic tk, input logic [7:0] e);
        place_a = pa;
        place_b = pb;
        tick    = tk;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        mon_q.push_back({hit_a, hit_b, health_a, health_b, game_state});
        place_a = 1'b0;
        place_b = 1'b0;
        tick    = 1'b0;
    endtask

    task automatic move(input logic [3:0] ax, input logic [3:0] ay,
                        input logic [3:0] bx, input logic [3:0] by);
        pa_x = ax; pa_y = ay; pb_x = bx; pb_y = by;
    endtask

    task automatic query(input logic [3:0] x, input logic [3:0] y);
        qry_x = x;
        qry_y = y;
        #1;
    endtask

    task automatic do_reset();
        place_a  = 1'b0;
        place_b  = 1'b0;
        tick     = 1'b0;
        reset_sw = 1'b1;
        @(posedge clk);
        #1;
        reset_sw = 1'b0;
    endtask

    // A bomb dropped at (0,0), players then moved to the given cells for detonation.
    task automatic blast_round(input logic [3:0] ax, input logic [3:0] ay,
                               input logic [3:0] bx, input logic [3:0] by,
                               input logic [1:0] ha, input logic [1:0] hb,
                               input logic da, input logic db, input logic [1:0] gs_after,
                               input logic clear);
        logic [1:0] nha, nhb;
        nha = ha - {1'b0, da};
        nhb = hb - {1'b0, db};
        move(4'd0, 4'd0, 4'd9, 4'd9);
        step(1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, ha, hb, 2'd0));
        move(ax, ay, bx, by);
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, ha, hb, 2'd0));
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, ha, hb, 2'd0));
        step(1'b0, 1'b0, 1'b1, ex(da, db, nha, nhb, gs_after));
        if (clear) step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, nha, nhb, gs_after));
    endtask

    task automatic test_reset();
        logic [7:0] e, a;
        int k = 0;
        do_reset();
        move(4'd0, 4'd0, 4'd9, 4'd9);
        step(1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        query(4'd0, 4'd0);
        n_tests++;
        if (qry_bomb !== 1'b0 || qry_blast !== 1'b0) begin
            n_fail++;
            $display("FAIL reset qry(0,0): got bomb=%b blast=%b want 0 0", qry_bomb, qry_blast);
        end
        while (sb_q.size() > 0 && mon_q.size() > 0) begin
            e = sb_q.pop_front(); a = mon_q.pop_front(); n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL reset obs[%0d] {hitA,hitB,hpA,hpB,gs}: got %b want %b", k, a, e);
            end
            k++;
        end
    endtask

    task automatic test_single();
        logic [7:0] e, a;
        int k = 0;
        do_reset();
        move(4'd1, 4'd1, 4'd9, 4'd9);
        step(1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        query(4'd1, 4'd1);
        n_tests++;
        if (qry_bomb !== 1'b1) begin
            n_fail++; $display("FAIL single qry_bomb(1,1) after place: got %b want 1", qry_bomb);
        end
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        step(1'b0, 1'b0, 1'b1, ex(1'b1, 1'b0, 2'd2, 2'd3, 2'd0));
        query(4'd1, 4'd1);
        n_tests++;
        if (qry_bomb !== 1'b0 || qry_blast !== 1'b1) begin
            n_fail++; $display("FAIL single qry(1,1) in blast: got bomb=%b blast=%b want 0 1", qry_bomb, qry_blast);
        end
        query(4'd1, 4'd3);
        n_tests++;
        if (qry_blast !== 1'b1) begin
            n_fail++; $display("FAIL single qry_blast(1,3): got %b want 1", qry_blast);
        end
        query(4'd1, 4'd4);
        n_tests++;
        if (qry_blast !== 1'b0) begin
            n_fail++; $display("FAIL single qry_blast(1,4): got %b want 0", qry_blast);
        end
        step(1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd2, 2'd3, 2'd0));
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd2, 2'd3, 2'd0));
        query(4'd1, 4'd3);
        n_tests++;
        if (qry_blast !== 1'b0) begin
            n_fail++; $display("FAIL single qry_blast(1,3) after clear: got %b want 0", qry_blast);
        end
        while (sb_q.size() > 0 && mon_q.size() > 0) begin
            e = sb_q.pop_front(); a = mon_q.pop_front(); n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL single obs[%0d] {hitA,hitB,hpA,hpB,gs}: got %b want %b", k, a, e);
            end
            k++;
        end
    endtask

    task automatic test_slots();
        logic [7:0] e, a;
        logic [7:0] idle;
        int k = 0;
        idle = ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            move(4'(2 + i), 4'd2, 4'd9, 4'd9);
            step(1'b1, 1'b0, 1'b0, idle);
        end
        for (int i = 0; i < 3; i++) begin
            query(4'(2 + i), 4'd2);
            n_tests++;
            if (qry_bomb !== (i < 2)) begin
                n_fail++; $display("FAIL slots qry_bomb(%0d,2): got %b want %b", 2 + i, qry_bomb, i < 2);
            end
        end
        move(4'd9, 4'd9, 4'd9, 4'd9);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, idle);
        move(4'd4, 4'd2, 4'd9, 4'd9);
        step(1'b1, 1'b0, 1'b0, idle);
        query(4'd4, 4'd2);
        n_tests++;
        if (qry_bomb !== 1'b1) begin
            n_fail++; $display("FAIL slots qry_bomb(4,2) after reuse: got %b want 1", qry_bomb);
        end
        step(1'b1, 1'b0, 1'b0, idle);
        move(4'd10, 4'd3, 4'd9, 4'd9);
        step(1'b1, 1'b0, 1'b0, idle);
        query(4'd10, 4'd3);
        n_tests++;
        if (qry_bomb !== 1'b0) begin
            n_fail++; $display("FAIL slots qry_bomb(10,3) off-grid: got %b want 0", qry_bomb);
        end
        move(4'd6, 4'd6, 4'd9, 4'd9);
        step(1'b1, 1'b0, 1'b0, idle);
        query(4'd6, 4'd6);
        n_tests++;
        if (qry_bomb !== 1'b1) begin
            n_fail++; $display("FAIL slots qry_bomb(6,6) second slot: got %b want 1", qry_bomb);
        end
        while (sb_q.size() > 0 && mon_q.size() > 0) begin
            e = sb_q.pop_front(); a = mon_q.pop_front(); n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL slots obs[%0d] {hitA,hitB,hpA,hpB,gs}: got %b want %b", k, a, e);
            end
            k++;
        end
    endtask

    task automatic test_same_cell();
        logic [7:0] e, a;
        logic [7:0] idle;
        int k = 0;
        idle = ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0);
        do_reset();
        move(4'd5, 4'd5, 4'd5, 4'd5);
        step(1'b1, 1'b1, 1'b0, idle);
        query(4'd5, 4'd5);
        n_tests++;
        if (qry_bomb !== 1'b1) begin
            n_fail++; $display("FAIL same_cell qry_bomb(5,5): got %b want 1", qry_bomb);
        end
        move(4'd0, 4'd0, 4'd7, 4'd7);
        step(1'b0, 1'b1, 1'b0, idle);
        move(4'd0, 4'd0, 4'd8, 4'd8);
        step(1'b0, 1'b1, 1'b0, idle);
        query(4'd7, 4'd7);
        n_tests++;
        if (qry_bomb !== 1'b1) begin
            n_fail++; $display("FAIL same_cell B qry_bomb(7,7): got %b want 1", qry_bomb);
        end
        query(4'd8, 4'd8);
        n_tests++;
        if (qry_bomb !== 1'b1) begin
            n_fail++; $display("FAIL same_cell B qry_bomb(8,8): got %b want 1", qry_bomb);
        end
        while (sb_q.size() > 0 && mon_q.size() > 0) begin
            e = sb_q.pop_front(); a = mon_q.pop_front(); n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL same_cell obs[%0d] {hitA,hitB,hpA,hpB,gs}: got %b want %b", k, a, e);
            end
            k++;
        end
    endtask

    task automatic test_overlap();
        logic [7:0] e, a;
        int k = 0;
        do_reset();
        move(4'd3, 4'd3, 4'd9, 4'd9);
        step(1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        move(4'd3, 4'd4, 4'd9, 4'd9);
        step(1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        move(4'd3, 4'd5, 4'd3, 4'd2);
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        step(1'b0, 1'b0, 1'b1, ex(1'b1, 1'b1, 2'd2, 2'd2, 2'd0));
        step(1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd2, 2'd2, 2'd0));
        while (sb_q.size() > 0 && mon_q.size() > 0) begin
            e = sb_q.pop_front(); a = mon_q.pop_front(); n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL overlap obs[%0d] {hitA,hitB,hpA,hpB,gs}: got %b want %b", k, a, e);
            end
            k++;
        end
    endtask

    task automatic test_place_tick();
        logic [7:0] e, a;
        logic [7:0] idle;
        int k = 0;
        idle = ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0);
        do_reset();
        move(4'd0, 4'd0, 4'd7, 4'd7);
        step(1'b1, 1'b0, 1'b0, idle);
        step(1'b0, 1'b0, 1'b1, idle);
        move(4'd9, 4'd9, 4'd7, 4'd7);
        step(1'b1, 1'b0, 1'b1, idle);
        move(4'd5, 4'd5, 4'd7, 4'd7);
        step(1'b0, 1'b0, 1'b1, idle);
        query(4'd0, 4'd2);
        n_tests++;
        if (qry_blast !== 1'b1) begin
            n_fail++; $display("FAIL place_tick qry_blast(0,2): got %b want 1", qry_blast);
        end
        step(1'b0, 1'b0, 1'b1, idle);
        query(4'd9, 4'd9);
        n_tests++;
        if (qry_bomb !== 1'b1) begin
            n_fail++; $display("FAIL place_tick qry_bomb(9,9) still fusing: got %b want 1", qry_bomb);
        end
        step(1'b0, 1'b0, 1'b1, idle);
        query(4'd7, 4'd9);
        n_tests++;
        if (qry_blast !== 1'b1) begin
            n_fail++; $display("FAIL place_tick qry_blast(7,9): got %b want 1", qry_blast);
        end
        query(4'd10, 4'd9);
        n_tests++;
        if (qry_blast !== 1'b0) begin
            n_fail++; $display("FAIL place_tick qry_blast(10,9) off-grid: got %b want 0", qry_blast);
        end
        while (sb_q.size() > 0 && mon_q.size() > 0) begin
            e = sb_q.pop_front(); a = mon_q.pop_front(); n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL place_tick obs[%0d] {hitA,hitB,hpA,hpB,gs}: got %b want %b", k, a, e);
            end
            k++;
        end
    endtask

    task automatic test_draw();
        logic [7:0] e, a;
        int k = 0;
        do_reset();
        blast_round(4'd0, 4'd1, 4'd1, 4'd0, 2'd3, 2'd3, 1'b1, 1'b1, 2'd0, 1'b1);
        blast_round(4'd0, 4'd1, 4'd1, 4'd0, 2'd2, 2'd2, 1'b1, 1'b1, 2'd0, 1'b1);
        blast_round(4'd0, 4'd1, 4'd1, 4'd0, 2'd1, 2'd1, 1'b1, 1'b1, 2'd3, 1'b0);
        move(4'd5, 4'd5, 4'd6, 4'd6);
        step(1'b1, 1'b1, 1'b1, ex(1'b0, 1'b0, 2'd0, 2'd0, 2'd3));
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd0, 2'd0, 2'd3));
        query(4'd5, 4'd5);
        n_tests++;
        if (qry_bomb !== 1'b0) begin
            n_fail++; $display("FAIL draw qry_bomb(5,5) after game over: got %b want 0", qry_bomb);
        end
        query(4'd0, 4'd1);
        n_tests++;
        if (qry_blast !== 1'b1) begin
            n_fail++; $display("FAIL draw frozen qry_blast(0,1): got %b want 1", qry_blast);
        end
        while (sb_q.size() > 0 && mon_q.size() > 0) begin
            e = sb_q.pop_front(); a = mon_q.pop_front(); n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL draw obs[%0d] {hitA,hitB,hpA,hpB,gs}: got %b want %b", k, a, e);
            end
            k++;
        end
    endtask

    task automatic test_win();
        logic [7:0] e, a;
        int k = 0;
        do_reset();
        blast_round(4'd9, 4'd9, 4'd1, 4'd0, 2'd3, 2'd3, 1'b0, 1'b1, 2'd0, 1'b1);
        blast_round(4'd9, 4'd9, 4'd1, 4'd0, 2'd3, 2'd2, 1'b0, 1'b1, 2'd0, 1'b1);
        blast_round(4'd9, 4'd9, 4'd1, 4'd0, 2'd3, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1);
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd3, 2'd0, 2'd1));
        while (sb_q.size() > 0 && mon_q.size() > 0) begin
            e = sb_q.pop_front(); a = mon_q.pop_front(); n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL win obs[%0d] {hitA,hitB,hpA,hpB,gs}: got %b want %b", k, a, e);
            end
            k++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e, a;
        int k = 0;
        do_reset();
        move(4'd0, 4'd0, 4'd1, 4'd0);
        step(1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        move(4'd0, 4'd1, 4'd1, 4'd0);
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        tick     = 1'b1;
        reset_sw = 1'b1;
        query(4'd0, 4'd0);
        n_tests++;
        if (qry_bomb !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid qry_bomb(0,0) during reset: got %b want 0", qry_bomb);
        end
        sb_q.push_back(ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        @(posedge clk);
        #1;
        reset_sw = 1'b0;
        tick     = 1'b0;
        mon_q.push_back({hit_a, hit_b, health_a, health_b, game_state});
        query(4'd0, 4'd1);
        n_tests++;
        if (qry_bomb !== 1'b0 || qry_blast !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid qry(0,1) after release: got bomb=%b blast=%b want 0 0", qry_bomb, qry_blast);
        end
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        step(1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd3, 2'd3, 2'd0));
        while (sb_q.size() > 0 && mon_q.size() > 0) begin
            e = sb_q.pop_front(); a = mon_q.pop_front(); n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL reset_mid obs[%0d] {hitA,hitB,hpA,hpB,gs}: got %b want %b", k, a, e);
            end
            k++;
        end
    endtask

    initial begin
        reset_sw = 1'b1;
        tick     = 1'b0;
        place_a  = 1'b0;
        place_b  = 1'b0;
        move(4'd0, 4'd0, 4'd9, 4'd9);
        qry_x    = 4'd0;
        qry_y    = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_slots();
        test_same_cell();
        test_overlap();
        test_place_tick();
        test_draw();
        test_win();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
